sp_floyd_engine: RTL and testbench
==================================

// Module: sp_floyd_engine
// PURPOSE
//  Parametrised all-pairs shortest-path engine (Floyd-Warshall, in place) for N=2**LOG_N nodes.
//  Reads/updates distance matrix in SRAM M, writes intermediate-node matrix to SRAM P via
//  port A of dp_sram_coregen; port B stays free for host load/readback. Adds row skip, Mode, counters.
// PARAMETERS
//  LOG_N    3   log2 node count; N=2**LOG_N, entry (i,j) at addr {i,j}, zero-extended
//  D_WIDTH  8   distance/node-id width; INF = all ones; require N <= 2**D_WIDTH-1
//  A_WIDTH  13  SRAM address width; require A_WIDTH >= 2*LOG_N
// PORTS
//  Clk      in  1        clock, all state on rising edge
//  Rst_n    in  1        async active-low reset
//  Go       in  1        start pulse; sampled only in IDLE/DONE
//  Mode     in  1        0: full (D and P), 1: distance only (P never written); latched on Go
//  M_In     in  D_WIDTH  SRAM M read data, valid 1 cycle after M_En&!M_We
//  M_Out    out D_WIDTH  SRAM M write data
//  M_Addr   out A_WIDTH  SRAM M address
//  M_En     out 1        SRAM M enable
//  M_We     out 1        SRAM M write enable
//  P_Out    out D_WIDTH  SRAM P write data
//  P_Addr   out A_WIDTH  SRAM P address
//  P_En     out 1        SRAM P enable (writes only)
//  P_We     out 1        SRAM P write enable
//  Busy     out 1        high from cycle after accepted Go until DONE entered
//  Done     out 1        level, high in DONE until next accepted Go
//  Upd_Cnt  out 16       number of relaxations performed this run, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; k,i,j counters 0; Upd_Cnt 0. Async reset mid-run aborts
//   immediately, no further SRAM access; SRAM contents then undefined.
//  IDLE/DONE --Go--> INIT_P (Mode=0) or RD_IK (Mode=1); Upd_Cnt cleared, Done dropped same edge.
//  INIT_P: one P write/cycle, P[a]=INF for a=0..N*N-1 in order; N*N cycles, then RD_IK.
//  Loop order k outer, i middle, j inner, each 0..N-1.
//  RD_IK: issue read M[{i,k}]. WAIT_IK: capture D_ik. If D_ik==INF skip row: advance i
//   (next RD_IK) without any j access.
//  Per j (3 cycles, 4 if relaxing):
//   RD_KJ  issue read M[{k,j}]
//   RD_IJ  issue read M[{i,j}]; capture D_kj
//   CMP    capture D_ij; sum = D_ik + D_kj in D_WIDTH+1 bits;
//          relax iff D_kj!=INF && sum<INF && sum<D_ij
//   WR     (relax only) M[{i,j}]<=sum[D_WIDTH-1:0]; if Mode=0, P[{i,j}]<=k, same cycle
//  Advance j; j wrap -> i++ (RD_IK); i wrap -> k++; k wrap -> DONE. No wrap of Upd_Cnt.
//  Ties (sum==D_ij): no update, P keeps earliest k. i==k or j==k processed normally (never relax).
//  Go while Busy ignored. Single M access per cycle; M_En low in WAIT_IK if no access.
//  Results equal software FW with same tie rule, bit-exact.
// STRUCTURE
//  Package sp_pkg: state enum (IDLE, INIT_P, RD_IK, WAIT_IK, RD_KJ, RD_IJ, CMP, WR, DONE),
//   function addr_of(i,j), INF constant derived from D_WIDTH.
//  Sub-module sp_relax_unit: combinational sum/saturate/compare, outputs relax + sum.
//  Top: FSM, k/i/j counters, address mux, Upd_Cnt.
// TESTING (LOG_N=2, D_WIDTH=8, M preloaded via port B, Rst_n low 2 cycles first)
//  1 Line 0-1-2-3 weights 1, diag 0, rest FF, Mode=0 -> D[0][3]=03, P[0][3]=02, P[0][1]=FF, Done.
//  2 All-FF off-diagonal, Mode=0 -> M unchanged, P all FF except none written, Upd_Cnt=0;
//    every RD_IK on i!=k row skips (no RD_KJ seen).
//  3 Weights FE,FE via node1 (0->1,1->2), D[0][2]=FF -> sum 1FC>=FF: no relax, D[0][2]=FF.
//  4 Tie: D[0][2]=02, D[0][1]=D[1][2]=01 -> D[0][2]=02 unchanged, P[0][2]=FF.
//  5 Mode=1 on case 1 -> D identical to case 1, P_En never asserted.
//  6 Drop Rst_n during k=1 -> outputs 0 next sample, Busy=0; new Go reruns and matches case 1.

Source files
------------

// File: rtl/sp_floyd_engine_pkg.sv
// sp_pkg: shared FSM states and address/INF helpers for the Floyd-Warshall engine.
package sp_pkg;
    typedef enum logic [3:0] {IDLE, INIT_P, RD_IK, WAIT_IK, RD_KJ, RD_IJ, CMP, WR, DONE} state_t;

    function automatic logic [31:0] addr_of(input logic [15:0] i, input logic [15:0] j, input int log_n);
        return (32'(i) << log_n) | 32'(j);
    endfunction

    function automatic logic [31:0] inf_of(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/sp_floyd_engine_relax.sv
// sp_relax_unit: combinational path-sum and relaxation decision for one (i,k,j) triple.
module sp_relax_unit
    import sp_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic [D_WIDTH-1:0] d_ik,
    input  logic [D_WIDTH-1:0] d_kj,
    input  logic [D_WIDTH-1:0] d_ij,
    output logic               relax,
    output logic [D_WIDTH-1:0] sum
);
    localparam logic [D_WIDTH-1:0] INF = D_WIDTH'(inf_of(D_WIDTH));
    logic [D_WIDTH:0] s;

    assign s     = {1'b0, d_ik} + {1'b0, d_kj};
    assign sum   = s[D_WIDTH-1:0];
    // strict less-than keeps the earliest intermediate node on ties
    assign relax = (d_kj != INF) && (s < {1'b0, INF}) && (s < {1'b0, d_ij});
endmodule

// File: rtl/sp_floyd_engine.sv
// sp_floyd_engine: in-place all-pairs shortest-path engine over SRAM M (distances)
// and SRAM P (intermediate nodes), one M access per cycle.
module sp_floyd_engine
    import sp_pkg::*;
#(
    parameter int LOG_N   = 3,
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 13
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Go,
    input  logic               Mode,
    input  logic [D_WIDTH-1:0] M_In,
    output logic [D_WIDTH-1:0] M_Out,
    output logic [A_WIDTH-1:0] M_Addr,
    output logic               M_En,
    output logic               M_We,
    output logic [D_WIDTH-1:0] P_Out,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic               P_En,
    output logic               P_We,
    output logic               Busy,
    output logic               Done,
    output logic [15:0]        Upd_Cnt
);
    localparam logic [D_WIDTH-1:0] INF = D_WIDTH'(inf_of(D_WIDTH));

    state_t state, state_n, adv_i_s, adv_j_s;
    logic [LOG_N-1:0] k, i, j;
    logic [D_WIDTH-1:0] d_ik, d_kj, sum_r, sum;
    logic mode_r, relax, go_acc, last_i, last_j, last_k, skip, step_j, step_i;

    assign go_acc = Go && (state == IDLE || state == DONE);
    assign last_i = &i;
    assign last_j = &j;
    assign last_k = &k;
    assign skip   = (state == WAIT_IK) && (M_In == INF);
    assign step_j = (state == CMP && !relax) || state == WR;
    assign step_i = skip || (step_j && last_j);

    sp_relax_unit #(.D_WIDTH(D_WIDTH)) u_relax (
        .d_ik (d_ik),
        .d_kj (d_kj),
        .d_ij (M_In),
        .relax(relax),
        .sum  (sum)
    );

    always_comb begin
        adv_i_s = (last_i && last_k) ? DONE : RD_IK;
        adv_j_s = last_j ? adv_i_s : RD_KJ;
        state_n = state;
        case (state)
            IDLE, DONE: state_n = go_acc ? (Mode ? RD_IK : INIT_P) : state;
            INIT_P:     state_n = (last_i && last_j) ? RD_IK : INIT_P;
            RD_IK:      state_n = WAIT_IK;
            WAIT_IK:    state_n = skip ? adv_i_s : RD_KJ;
            RD_KJ:      state_n = RD_IJ;
            RD_IJ:      state_n = CMP;
            CMP:        state_n = relax ? WR : adv_j_s;
            WR:         state_n = adv_j_s;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            k       <= '0;
            i       <= '0;
            j       <= '0;
            d_ik    <= '0;
            d_kj    <= '0;
            sum_r   <= '0;
            mode_r  <= 1'b0;
            Upd_Cnt <= '0;
        end else begin
            state <= state_n;
            if (go_acc) begin
                k       <= '0;
                i       <= '0;
                j       <= '0;
                mode_r  <= Mode;
                Upd_Cnt <= '0;
            end
            // INIT_P reuses {i,j} as a flat address counter; it wraps back to 0
            if (state == INIT_P) {i, j} <= {i, j} + (2*LOG_N)'(1);
            if (state == WAIT_IK) d_ik <= M_In;
            if (state == RD_IJ) d_kj <= M_In;
            if (state == CMP) sum_r <= sum;
            if (state == CMP && relax && Upd_Cnt != 16'hFFFF) Upd_Cnt <= Upd_Cnt + 16'd1;
            if (step_j) j <= j + LOG_N'(1);
            if (step_i) begin
                i <= i + LOG_N'(1);
                if (last_i) k <= k + LOG_N'(1);
            end
        end
    end

    assign M_En   = state inside {RD_IK, RD_KJ, RD_IJ, WR};
    assign M_We   = state == WR;
    assign M_Out  = sum_r;
    assign M_Addr = A_WIDTH'(state == RD_IK ? addr_of(16'(i), 16'(k), LOG_N) :
                             state == RD_KJ ? addr_of(16'(k), 16'(j), LOG_N) :
                                              addr_of(16'(i), 16'(j), LOG_N));
    assign P_En   = state == INIT_P || (state == WR && !mode_r);
    assign P_We   = P_En;
    assign P_Addr = A_WIDTH'(addr_of(16'(i), 16'(j), LOG_N));
    assign P_Out  = state == INIT_P ? INF : D_WIDTH'(k);
    assign Busy   = state != IDLE && state != DONE;
    assign Done   = state == DONE;
endmodule

// File: tb/tb_sp_floyd_engine.sv
// tb_sp_floyd_engine: scoreboard bench comparing each finished run against a software Floyd-Warshall model.
module tb_sp_floyd_engine;
    typedef logic [15:0][7:0] mat_t;
    typedef struct packed {
        mat_t        d;
        mat_t        p;
        logic [15:0] upd;
        logic [31:0] macc;
        logic [31:0] pwr;
    } exp_t;

    logic        Clk = 1'b0, Rst_n = 1'b0, Go = 1'b0, Mode = 1'b0;
    logic [7:0]  M_In, M_Out, P_Out;
    logic [12:0] M_Addr, P_Addr;
    logic        M_En, M_We, P_En, P_We, Busy, Done;
    logic [15:0] Upd_Cnt;

    logic [7:0] mmem [16];
    logic [7:0] pmem [16];
    exp_t sb[$];
    int checks = 0, failures = 0, m_acc = 0, p_wr = 0;
    logic done_q = 1'b0;

    sp_floyd_engine #(.LOG_N(2), .D_WIDTH(8), .A_WIDTH(13)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .Mode(Mode), .M_In(M_In), .M_Out(M_Out),
        .M_Addr(M_Addr), .M_En(M_En), .M_We(M_We), .P_Out(P_Out), .P_Addr(P_Addr),
        .P_En(P_En), .P_We(P_We), .Busy(Busy), .Done(Done), .Upd_Cnt(Upd_Cnt)
    );

    always #5 Clk = ~Clk;

    // port A of both SRAMs: synchronous read with one-cycle latency
    always @(posedge Clk) begin
        if (M_En) begin
            if (M_We) mmem[M_Addr[3:0]] <= M_Out;
            else M_In <= mmem[M_Addr[3:0]];
        end
        if (P_En && P_We) pmem[P_Addr[3:0]] <= P_Out;
        if (M_En) m_acc = m_acc + 1;
        if (P_En && P_We) p_wr = p_wr + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input mat_t m0, input mat_t p0, input logic mode);
        exp_t e;
        int s;
        logic [7:0] dik;
        e.d = m0;
        e.p = mode ? p0 : {16{8'hFF}};
        e.upd = '0;
        e.macc = '0;
        e.pwr = mode ? 32'd0 : 32'd16;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                e.macc = e.macc + 1;
                dik = e.d[i*4+k];
                if (dik != 8'hFF)
                    for (int j = 0; j < 4; j++) begin
                        e.macc = e.macc + 2;
                        s = int'(dik) + int'(e.d[k*4+j]);
                        if (e.d[k*4+j] != 8'hFF && s < 255 && s < int'(e.d[i*4+j])) begin
                            e.d[i*4+j] = 8'(s);
                            e.upd = e.upd + 1;
                            e.macc = e.macc + 1;
                            if (!mode) begin
                                e.p[i*4+j] = 8'(k);
                                e.pwr = e.pwr + 1;
                            end
                        end
                    end
            end
        return e;
    endfunction

    function automatic mat_t blank();
        mat_t m = {16{8'hFF}};
        for (int n = 0; n < 4; n++) m[n*5] = 8'h00;
        return m;
    endfunction

    // monitor: every rising Done retires one expected result
    always @(negedge Clk) begin
        exp_t e;
        if (Done && !done_q) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                for (int n = 0; n < 16; n++) begin
                    check($sformatf("D[%0d][%0d]", n / 4, n % 4), 32'(mmem[n]), 32'(e.d[n]));
                    check($sformatf("P[%0d][%0d]", n / 4, n % 4), 32'(pmem[n]), 32'(e.p[n]));
                end
                check("upd_cnt", 32'(Upd_Cnt), 32'(e.upd));
                check("m_accesses", m_acc, e.macc);
                check("p_writes", p_wr, e.pwr);
            end
        end
        done_q = Done;
    end

    task automatic go_pulse(input logic mode);
        mat_t dummy;
        Mode = mode;
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        Mode = 1'($urandom);
        dummy = '0;
    endtask

    task automatic run(input mat_t m, input logic mode, input logic poke);
        mat_t p0;
        int n = 0;
        for (int a = 0; a < 16; a++) begin
            p0[a] = 8'($urandom_range(0, 254));
            mmem[a] = m[a];
            pmem[a] = p0[a];
        end
        sb.push_back(model(m, p0, mode));
        m_acc = 0;
        p_wr = 0;
        go_pulse(mode);
        check("busy_after_go", {31'd0, Busy}, 32'd1);
        check("done_dropped", {31'd0, Done}, 32'd0);
        while (!Done && n < 5000) begin
            Go = poke && n == 20;
            @(negedge Clk);
            n++;
        end
        Go = 1'b0;
        if (!Done) check("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        mat_t line, m;
        int n;
        for (int a = 0; a < 16; a++) begin
            mmem[a] = 8'h00;
            pmem[a] = 8'h00;
        end
        repeat (2) @(negedge Clk);
        check("reset_outputs", {M_Out, P_Out, M_En, M_We, P_En, P_We, Busy, Done, Upd_Cnt[1:0]}, 32'd0);
        check("reset_addr", {M_Addr, P_Addr, Upd_Cnt[15:10]}, 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        line = blank();
        line[1] = 8'h01; line[6] = 8'h01; line[11] = 8'h01;
        run(line, 1'b0, 1'b0);
        check("line_d03", 32'(mmem[3]), 32'h03);
        check("line_p03", 32'(pmem[3]), 32'h02);
        check("line_p01", 32'(pmem[1]), 32'hFF);
        check("line_done", {31'd0, Done}, 32'd1);

        run(blank(), 1'b0, 1'b0);
        check("noedge_upd", 32'(Upd_Cnt), 32'd0);

        m = blank();
        m[1] = 8'hFE; m[6] = 8'hFE;
        run(m, 1'b0, 1'b0);
        check("sat_d02", 32'(mmem[2]), 32'hFF);

        m = blank();
        m[2] = 8'h02; m[1] = 8'h01; m[6] = 8'h01;
        run(m, 1'b0, 1'b0);
        check("tie_d02", 32'(mmem[2]), 32'h02);
        check("tie_p02", 32'(pmem[2]), 32'hFF);

        run(line, 1'b1, 1'b0);
        check("mode1_d03", 32'(mmem[3]), 32'h03);
        check("mode1_pwr", p_wr, 32'd0);

        // abort mid-run at the first relaxation (k=1 for the line graph)
        for (int a = 0; a < 16; a++) mmem[a] = line[a];
        go_pulse(1'b0);
        n = 0;
        while (Upd_Cnt == 16'd0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("abort_reached_k1", {31'd0, Upd_Cnt == 16'd0}, 32'd0);
        Rst_n = 1'b0;
        #1;
        check("abort_outputs", {M_En, M_We, P_En, P_We, Busy, Done, Upd_Cnt[9:0]}, 32'd0);
        check("abort_addr", {M_Addr, P_Addr, M_Out[5:0]}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        run(line, 1'b0, 1'b0);
        check("rerun_d03", 32'(mmem[3]), 32'h03);

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) begin
                n = $urandom_range(0, 9);
                m[a] = n < 4 ? 8'hFF : n < 6 ? 8'($urandom_range(200, 254)) : 8'($urandom_range(0, 20));
            end
            if (r < 5) for (int d = 0; d < 4; d++) m[d*5] = 8'h00;
            run(m, 1'($urandom), r[0]);
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
